clint_tl_arbiter: RTL and testbench
===================================

// Module: clint_tl_arbiter
// PURPOSE
//  Shares the single TileLink-UL slave port of the CLINT between NREQ masters (harts / debug).
//  Round-robin arbitration on channel A, with one registered A stage and an outstanding-request credit limit.
//  Each requester index is prepended to the forwarded source so D responses route back combinationally.
//  Sits between the per-hart uncached ports and the CLINT.
// PARAMETERS
//  NREQ    2  number of requesting masters (>=1)
//  TL_RS   4  upstream source-ID width; downstream source width = TL_RS+IW, IW = (NREQ==1)?1:$clog2(NREQ)
//  MAXOUT  4  max requests accepted from masters but not yet answered on D (1..15)
// PORTS
//  arb_clock_i  in   1                clock
//  arb_reset_i  in   1                synchronous, active-high reset
//  m_a_bits     in   NREQ*(TL_RS+62)  per master {source,size[3:0],data[31:0],mask[3:0],opcode[2:0],param[2:0],address[15:0]}
//  m_a_valid    in   NREQ             per-master A valid
//  m_a_ready    out  NREQ             per-master A ready (one-hot or zero)
//  m_d_bits     out  TL_RS+43         broadcast {opcode[2:0],param[1:0],size[3:0],source,denied,data[31:0],corrupt}
//  m_d_valid    out  NREQ             per-master D valid (one-hot or zero)
//  m_d_ready    in   NREQ             per-master D ready
//  s_a_bits     out  TL_RS+IW+62      to CLINT, same layout, source = {index[IW-1:0], master source}
//  s_a_valid    out  1                to CLINT A valid (registered)
//  s_a_ready    in   1                CLINT A ready
//  s_d_bits     in   TL_RS+IW+43      from CLINT D, same layout as m_d_bits with widened source
//  s_d_valid    in   1                CLINT D valid
//  s_d_ready    out  1                CLINT D ready
//  arb_err_o    out  1                one-cycle pulse: D response with index >= NREQ was dropped
// BEHAVIOUR
//  Reset values: s_a_valid=0, s_a_bits=0, outstanding count=0, rr pointer=NREQ-1 (master 0 first), arb_err_o=0.
//  All other outputs are combinational from these registers and the inputs.
//  A stage:
//   - Single register slot, states EMPTY / FULL (FULL == s_a_valid).
//   - free = !s_a_valid | s_a_ready.
//   - credit = (count < MAXOUT).
//   - grant: first i with m_a_valid[i], searching from rr+1 modulo NREQ.
//   - m_a_ready[grant] = free & credit; all other m_a_ready = 0.
//  On accept (m_a_valid[g] & m_a_ready[g]):
//   - s_a_bits <= m_a_bits[g] with source prefixed by g;
//   - s_a_valid <= 1; rr <= g.
//   - Latency: master accept at cycle N -> s_a_valid at N+1.
//   - Back-to-back accepts allowed while s_a_ready=1 (throughput 1/cycle).
//  If s_a_ready & no accept this cycle -> s_a_valid <= 0.
//  While s_a_valid & !s_a_ready, s_a_bits held stable (TL valid/data stability rule).
//  Fairness: a master holding valid is granted within NREQ accepts.
//  Credit counter:
//   - +1 on master A accept; -1 on s_d handshake (s_d_valid & s_d_ready); both in one cycle -> unchanged.
//   - count==MAXOUT -> all m_a_ready=0 until a D handshake; count never exceeds MAXOUT or underflows.
//  D routing (combinational, zero latency):
//   - idx = s_d source[TL_RS+IW-1:TL_RS];
//   - m_d_valid[idx] = s_d_valid; s_d_ready = m_d_ready[idx];
//   - m_d_bits = s_d_bits with the index bits stripped.
//   - idx >= NREQ (non-power-of-2 NREQ): s_d_ready=1 (sink), no m_d_valid, arb_err_o pulses next cycle;
//     count still decrements.
//  Opcodes, params, mask and data pass through unmodified; no beat splitting (single-beat UL only).
//  Reset mid-operation: pending A slot discarded and count cleared. The CLINT is reset by the same reset.
// TESTING
//  1. Reset, m_a_valid=2'b01, addr 16'hBFF8 Get, source 3:
//     m_a_ready[0]=1 at cycle 0, s_a_valid at cycle 1 with source {1'b0,4'd3}.
//     D with source {1'b0,4'd3} -> m_d_valid=2'b01, m_d source=3.
//  2. Both masters valid continuously, s_a_ready=1, D answered immediately:
//     grants alternate 0,1,0,1; each master gets exactly 4 of 8 accepts.
//  3. s_a_ready=0 for 5 cycles with s_a_valid=1: s_a_bits unchanged all 5 cycles; no m_a_ready asserted.
//  4. MAXOUT=4, D withheld: after 4 accepts all m_a_ready=0.
//     One D handshake -> exactly one further accept; count returns to 4.
//  5. Same-cycle A accept and D handshake at count=3: count stays 3, no stall.
//  6. NREQ=3, inject D with index 2'd3: s_d_ready=1, m_d_valid=3'b000, arb_err_o=1 for one cycle.
//     Reset asserted while s_a_valid=1 -> s_a_valid=0 next cycle.

Source files
------------

// File: rtl/clint_tl_arbiter.sv
// -----------------------------------------------------------------------------
// clint_tl_arbiter
//
// Shares the single TileLink-UL slave port of the CLINT between NREQ masters
// (harts / debug). Channel A is round-robin arbitrated into one registered
// slot; the winning requester index is prepended to the forwarded source so
// that channel D responses can be routed back combinationally. An outstanding
// request credit counter bounds how many accepted requests may still be
// waiting for their D response.
//
// A-stage slot state (ST_EMPTY / ST_FULL) is exported directly as s_a_valid.
//
// Handshake semantics (both channels, both sides): a beat transfers on a
// rising clock edge where valid and ready are both high. A valid, once
// raised, is held with stable bits until it transfers; ready may depend
// combinationally on valid.
//
// Ports
//   arb_clock_i  in   1                clock
//   arb_reset_i  in   1                synchronous, active-high reset
//   m_a_bits     in   NREQ*(TL_RS+62)  per master {source,size,data,mask,opcode,param,address}
//   m_a_valid    in   NREQ             per-master A valid
//   m_a_ready    out  NREQ             per-master A ready (one-hot or zero)
//   m_d_bits     out  TL_RS+43         broadcast {opcode,param,size,source,denied,data,corrupt}
//   m_d_valid    out  NREQ             per-master D valid (one-hot or zero)
//   m_d_ready    in   NREQ             per-master D ready
//   s_a_bits     out  TL_RS+IW+62      to CLINT, source = {index, master source}
//   s_a_valid    out  1                to CLINT A valid (registered)
//   s_a_ready    in   1                CLINT A ready
//   s_d_bits     in   TL_RS+IW+43      from CLINT D, widened source
//   s_d_valid    in   1                CLINT D valid
//   s_d_ready    out  1                CLINT D ready
//   arb_err_o    out  1                pulse: D response with index >= NREQ dropped
// -----------------------------------------------------------------------------
module clint_tl_arbiter #(
    parameter int NREQ   = 2,
    parameter int TL_RS  = 4,
    parameter int MAXOUT = 4,
    localparam int IW    = (NREQ == 1) ? 1 : $clog2(NREQ),
    localparam int AW    = TL_RS + 62,
    localparam int SAW   = TL_RS + IW + 62,
    localparam int DW    = TL_RS + 43,
    localparam int SDW   = TL_RS + IW + 43
) (
    input  logic                 arb_clock_i,
    input  logic                 arb_reset_i,
    input  logic [NREQ*AW-1:0]   m_a_bits,
    input  logic [NREQ-1:0]      m_a_valid,
    output logic [NREQ-1:0]      m_a_ready,
    output logic [DW-1:0]        m_d_bits,
    output logic [NREQ-1:0]      m_d_valid,
    input  logic [NREQ-1:0]      m_d_ready,
    output logic [SAW-1:0]       s_a_bits,
    output logic                 s_a_valid,
    input  logic                 s_a_ready,
    input  logic [SDW-1:0]       s_d_bits,
    input  logic                 s_d_valid,
    output logic                 s_d_ready,
    output logic                 arb_err_o
);

    localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);
    // Source field of a D beat starts above corrupt(1) + data(32) + denied(1).
    localparam int D_SRC_LSB = 34;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } a_state_t;

    a_state_t         a_state_q, a_state_d;
    logic [SAW-1:0]   a_bits_q, a_bits_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             gnt_found;
    logic [IW-1:0]    gnt_idx;
    logic [AW-1:0]    sel_bits;
    logic             free, credit, accept;

    logic [IW-1:0]    d_idx;
    logic             d_idx_ok, d_sel_ready, d_hs;

    // Round-robin search starting one past the last winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && m_a_valid[(int'(rr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel_bits = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IW'(k)) sel_bits = m_a_bits[k*AW +: AW];
        end
    end

    assign free   = (a_state_q == ST_EMPTY) | s_a_ready;
    assign credit = (cnt_q < MAXOUT_C);
    assign accept = gnt_found & free & credit;

    always_comb begin
        m_a_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            m_a_ready[k] = free & credit & gnt_found & (gnt_idx == IW'(k));
        end
    end

    // D routing: indices with no matching master are sunk and flagged.
    assign d_idx = s_d_bits[D_SRC_LSB + TL_RS +: IW];

    always_comb begin
        d_idx_ok    = 1'b0;
        d_sel_ready = 1'b0;
        m_d_valid   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (d_idx == IW'(k)) begin
                d_idx_ok     = 1'b1;
                d_sel_ready  = m_d_ready[k];
                m_d_valid[k] = s_d_valid;
            end
        end
    end

    assign s_d_ready = d_idx_ok ? d_sel_ready : 1'b1;
    assign d_hs      = s_d_valid & s_d_ready;
    assign m_d_bits  = {s_d_bits[SDW-1 -: 9], s_d_bits[D_SRC_LSB + TL_RS - 1:0]};

    always_comb begin
        a_state_d = a_state_q;
        a_bits_d  = a_bits_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        err_d     = s_d_valid & ~d_idx_ok;

        // A full slot that is not draining blocks accept (free=0), so its
        // bits stay stable until the CLINT takes them.
        if (accept) begin
            a_state_d = ST_FULL;
            a_bits_d  = {gnt_idx, sel_bits};
            rr_d      = gnt_idx;
        end else if (s_a_ready) begin
            a_state_d = ST_EMPTY;
        end

        if (accept && !d_hs) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!accept && d_hs && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge arb_clock_i) begin
        if (arb_reset_i) begin
            a_state_q <= ST_EMPTY;
            a_bits_q  <= '0;
            rr_q      <= IW'(NREQ - 1);
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            a_state_q <= a_state_d;
            a_bits_q  <= a_bits_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign s_a_valid = (a_state_q == ST_FULL);
    assign s_a_bits  = a_bits_q;
    assign arb_err_o = err_q;

endmodule

// File: tb/tb_clint_tl_arbiter.sv
module tb_clint_tl_arbiter;
  localparam int NREQ  = 2;
  localparam int TL_RS = 4;
  localparam int IW    = 1;
  localparam int AW    = TL_RS + 62;
  localparam int SSW   = TL_RS + IW;
  localparam int SAW   = SSW + 62;
  localparam int DW    = TL_RS + 43;
  localparam int SDW   = SSW + 43;
  localparam int IW3   = 2;
  localparam int SSW3  = TL_RS + IW3;
  localparam int SAW3  = SSW3 + 62;
  localparam int SDW3  = SSW3 + 43;

  // ---------------- clock / reset ----------------
  logic arb_clock_i = 1'b0;
  logic arb_reset_i;
  always #5 arb_clock_i = ~arb_clock_i;

  // DUT with NREQ=2
  logic [NREQ*AW-1:0] m_a_bits;
  logic [NREQ-1:0]    m_a_valid, m_a_ready;
  logic [DW-1:0]      m_d_bits;
  logic [NREQ-1:0]    m_d_valid, m_d_ready;
  logic [SAW-1:0]     s_a_bits;
  logic               s_a_valid, s_a_ready;
  logic [SDW-1:0]     s_d_bits;
  logic               s_d_valid, s_d_ready;
  logic               arb_err_o;

  // DUT with NREQ=3 (non-power-of-two index space)
  logic [3*AW-1:0]    m_a_bits3;
  logic [2:0]         m_a_valid3, m_a_ready3;
  logic [DW-1:0]      m_d_bits3;
  logic [2:0]         m_d_valid3, m_d_ready3;
  logic [SAW3-1:0]    s_a_bits3;
  logic               s_a_valid3, s_a_ready3;
  logic [SDW3-1:0]    s_d_bits3;
  logic               s_d_valid3, s_d_ready3;
  logic               arb_err3;

  clint_tl_arbiter #(.NREQ(2), .TL_RS(TL_RS), .MAXOUT(4)) dut (
    .arb_clock_i(arb_clock_i), .arb_reset_i(arb_reset_i),
    .m_a_bits(m_a_bits), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_d_bits(m_d_bits), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .s_a_bits(s_a_bits), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_d_bits(s_d_bits), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .arb_err_o(arb_err_o)
  );

  clint_tl_arbiter #(.NREQ(3), .TL_RS(TL_RS), .MAXOUT(4)) dut3 (
    .arb_clock_i(arb_clock_i), .arb_reset_i(arb_reset_i),
    .m_a_bits(m_a_bits3), .m_a_valid(m_a_valid3), .m_a_ready(m_a_ready3),
    .m_d_bits(m_d_bits3), .m_d_valid(m_d_valid3), .m_d_ready(m_d_ready3),
    .s_a_bits(s_a_bits3), .s_a_valid(s_a_valid3), .s_a_ready(s_a_ready3),
    .s_d_bits(s_d_bits3), .s_d_valid(s_d_valid3), .s_d_ready(s_d_ready3),
    .arb_err_o(arb_err3)
  );

  // ---------------- scoreboard ----------------
  logic [SAW-1:0]       exp_a_q[$];
  logic [NREQ+DW-1:0]   exp_d_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected beats whenever the DUT transfers on s_a or s_d.
  always @(negedge arb_clock_i) begin
    if (!arb_reset_i && s_a_valid && s_a_ready) begin
      if (exp_a_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL s_a_unexpected: got %0h, expected no beat", s_a_bits);
      end else begin
        chk("s_a_bits", s_a_bits, exp_a_q.pop_front());
      end
    end
    if (!arb_reset_i && s_d_valid && s_d_ready) begin
      if (exp_d_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL m_d_unexpected: got %0h, expected no beat", {m_d_valid, m_d_bits});
      end else begin
        chk("m_d_route", {m_d_valid, m_d_bits}, exp_d_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [AW-1:0] mk_a(input logic [3:0] src, input logic [31:0] data,
                                         input logic [15:0] addr, input logic [2:0] opc);
    return {src, 4'd2, data, 4'hF, opc, 3'd0, addr};
  endfunction

  task automatic tick();
    @(posedge arb_clock_i);
    #1;
  endtask

  task automatic do_reset();
    arb_reset_i = 1'b1;
    m_a_bits = '0;  m_a_valid = '0;  s_a_ready = 1'b0;
    s_d_bits = '0;  s_d_valid = 1'b0; m_d_ready = '0;
    m_a_bits3 = '0; m_a_valid3 = '0; s_a_ready3 = 1'b0;
    s_d_bits3 = '0; s_d_valid3 = 1'b0; m_d_ready3 = '0;
    repeat (2) @(posedge arb_clock_i);
    #1;
    arb_reset_i = 1'b0;
  endtask

  // CLINT-side D beat for dut; pushes the beat the addressed master should see.
  task automatic drive_d(input logic [SSW-1:0] src);
    logic [31:0] data;
    data = 32'hD000_0000 | 32'(src);
    s_d_bits  = {3'd1, 2'd0, 4'd2, src, 1'b0, data, 1'b0};
    s_d_valid = 1'b1;
    exp_d_q.push_back({(src[SSW-1] ? 2'b10 : 2'b01), 3'd1, 2'd0, 4'd2,
                       src[TL_RS-1:0], 1'b0, data, 1'b0});
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] b0, b1, b4;
  logic [SSW-1:0] pend[$];
  int acc0, acc1, n_acc;
  bit done;

  initial begin
    do_reset();

    // Reset state
    @(negedge arb_clock_i);
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_s_a_bits", s_a_bits, 0);
    chk("rst_err", arb_err_o, 0);
    chk("rst_m_d_valid", m_d_valid, 0);
    chk("rst_s_a_valid3", s_a_valid3, 0);

    // Test 1: single Get from master 0
    tick();
    b0 = mk_a(4'd3, 32'h0, 16'hBFF8, 3'd4);
    s_a_ready = 1'b1;
    m_a_bits[0 +: AW] = b0;
    m_a_valid = 2'b01;
    exp_a_q.push_back({1'b0, b0});
    @(negedge arb_clock_i);
    chk("t1_ready_c0", m_a_ready, 2'b01);
    chk("t1_valid_c0", s_a_valid, 0);
    tick();
    m_a_valid = 2'b00;
    @(negedge arb_clock_i);
    chk("t1_valid_c1", s_a_valid, 1);
    chk("t1_s_src", s_a_bits[SAW-1 -: SSW], 5'b0_0011);
    tick();
    m_d_ready = 2'b01;
    drive_d(5'b0_0011);
    @(negedge arb_clock_i);
    chk("t1_s_d_ready", s_d_ready, 1);
    chk("t1_m_d_src", m_d_bits[34 +: TL_RS], 4'd3);
    tick();
    s_d_valid = 1'b0;
    m_d_ready = '0;

    // Test 2: both masters valid, fair alternation over 8 accepts
    do_reset();
    b0 = mk_a(4'd1, 32'h1111_0000, 16'h0000, 3'd0);
    b1 = mk_a(4'd2, 32'h2222_0000, 16'h4000, 3'd0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_a_q.push_back({1'b0, b0});
      else            exp_a_q.push_back({1'b1, b1});
    end
    m_a_bits = {b1, b0};
    m_a_valid = 2'b11;
    s_a_ready = 1'b1;
    m_d_ready = 2'b11;
    acc0 = 0; acc1 = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge arb_clock_i);
      if (m_a_valid[0] && m_a_ready[0]) acc0++;
      if (m_a_valid[1] && m_a_ready[1]) acc1++;
      if (s_a_valid && s_a_ready) pend.push_back(s_a_bits[SAW-1 -: SSW]);
      tick();
      if (acc0 + acc1 >= 8) m_a_valid = 2'b00;
      if (pend.size() > 0) drive_d(pend.pop_front());
      else s_d_valid = 1'b0;
      done = (acc0 + acc1 >= 8) && (pend.size() == 0) && !s_a_valid && !s_d_valid;
    end
    chk("t2_completed", done, 1);
    chk("t2_acc_m0", acc0, 4);
    chk("t2_acc_m1", acc1, 4);
    m_d_ready = '0;

    // Test 3: downstream stall holds the slot
    do_reset();
    b0 = mk_a(4'd5, 32'hA5A5_0001, 16'h0004, 3'd0);
    b1 = mk_a(4'd6, 32'h5A5A_0002, 16'h0008, 3'd0);
    m_a_bits = {b1, b0};
    m_a_valid = 2'b01;
    exp_a_q.push_back({1'b0, b0});
    @(negedge arb_clock_i);
    chk("t3_ready_c0", m_a_ready, 2'b01);
    tick();
    m_a_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge arb_clock_i);
      chk("t3_stall_valid", s_a_valid, 1);
      chk("t3_stall_bits", s_a_bits, {1'b0, b0});
      chk("t3_stall_ready", m_a_ready, 2'b00);
      tick();
    end
    s_a_ready = 1'b1;
    exp_a_q.push_back({1'b1, b1});
    @(negedge arb_clock_i);
    chk("t3_release_grant", m_a_ready, 2'b10);
    tick();
    m_a_valid = 2'b00;
    @(negedge arb_clock_i);
    tick();

    // Test 4: credit limit with D withheld
    do_reset();
    b4 = mk_a(4'd3, 32'hCAFE_0000, 16'hBFF8, 3'd4);
    m_a_bits[0 +: AW] = b4;
    m_a_valid = 2'b01;
    s_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_a_q.push_back({1'b0, b4});
    n_acc = 0;
    for (int cyc = 0; cyc < 20 && n_acc < 4; cyc++) begin
      @(negedge arb_clock_i);
      if (m_a_valid[0] && m_a_ready[0]) n_acc++;
      tick();
    end
    chk("t4_accepts", n_acc, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge arb_clock_i);
      chk("t4_credit_stall", m_a_ready, 2'b00);
      tick();
    end
    m_d_ready = 2'b01;
    drive_d(5'b0_0011);
    @(negedge arb_clock_i);
    chk("t4_ready_during_d", m_a_ready, 2'b00);
    tick();
    s_d_valid = 1'b0;
    exp_a_q.push_back({1'b0, b4});
    @(negedge arb_clock_i);
    chk("t4_one_more", m_a_ready, 2'b01);
    tick();
    @(negedge arb_clock_i);
    chk("t4_full_again", m_a_ready, 2'b00);

    // Test 5: simultaneous accept and D handshake at count 3
    tick();
    m_a_valid = 2'b00;
    drive_d(5'b0_0011);                 // count 4 -> 3
    @(negedge arb_clock_i);
    tick();
    m_a_valid = 2'b01;
    drive_d(5'b0_0011);                 // accept + D: count stays 3
    exp_a_q.push_back({1'b0, b4});
    @(negedge arb_clock_i);
    chk("t5_no_stall", m_a_ready, 2'b01);
    tick();
    s_d_valid = 1'b0;
    exp_a_q.push_back({1'b0, b4});
    @(negedge arb_clock_i);
    chk("t5_count_held", m_a_ready, 2'b01);
    tick();
    @(negedge arb_clock_i);
    chk("t5_limit_reached", m_a_ready, 2'b00);
    tick();
    m_a_valid = 2'b00;
    m_d_ready = '0;
    repeat (2) tick();

    // Test 6: NREQ=3, out-of-range D index and mid-operation reset
    do_reset();
    m_d_ready3 = 3'b000;
    s_d_bits3 = {3'd1, 2'd0, 4'd2, 2'd3, 4'd5, 1'b0, 32'h0, 1'b0};
    s_d_valid3 = 1'b1;
    @(negedge arb_clock_i);
    chk("t6_sink_ready", s_d_ready3, 1);
    chk("t6_no_m_d_valid", m_d_valid3, 3'b000);
    chk("t6_err_not_yet", arb_err3, 0);
    tick();
    s_d_valid3 = 1'b0;
    @(negedge arb_clock_i);
    chk("t6_err_pulse", arb_err3, 1);
    tick();
    @(negedge arb_clock_i);
    chk("t6_err_clear", arb_err3, 0);
    tick();
    s_d_bits3 = {3'd1, 2'd0, 4'd2, 2'd2, 4'd7, 1'b0, 32'h1234_5678, 1'b0};
    s_d_valid3 = 1'b1;
    m_d_ready3 = 3'b100;
    @(negedge arb_clock_i);
    chk("t6_route_m2", m_d_valid3, 3'b100);
    chk("t6_route_bits", m_d_bits3, {3'd1, 2'd0, 4'd2, 4'd7, 1'b0, 32'h1234_5678, 1'b0});
    chk("t6_route_ready", s_d_ready3, 1);
    tick();
    m_d_ready3 = 3'b000;
    @(negedge arb_clock_i);
    chk("t6_backpressure", s_d_ready3, 0);
    tick();
    s_d_valid3 = 1'b0;
    m_a_bits3[AW +: AW] = mk_a(4'd9, 32'h0BAD_F00D, 16'h4000, 3'd0);
    m_a_valid3 = 3'b010;
    @(negedge arb_clock_i);
    chk("t6_grant_m1", m_a_ready3, 3'b010);
    tick();
    m_a_valid3 = 3'b000;
    @(negedge arb_clock_i);
    chk("t6_slot_full", s_a_valid3, 1);
    chk("t6_slot_src", s_a_bits3[SAW3-1 -: SSW3], {2'd1, 4'd9});
    tick();
    arb_reset_i = 1'b1;
    tick();
    arb_reset_i = 1'b0;
    @(negedge arb_clock_i);
    chk("t6_reset_drops_slot", s_a_valid3, 0);
    tick();

    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("d_queue_drained", exp_d_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
